// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and helpers for the ALU operand path
package alu_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Selector width that never collapses to zero bits for tiny N.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, scanning from ptr+1 upward
module rr_arbiter
    import alu_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_id
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int off = 1; off <= N; off++) begin
            w_idx = (int'(ptr) + off) % N;
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = SW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mux_n_para_1_reg.sv
// rtl/mux_n_para_1_reg.sv - N:1 W-bit mux with a one-entry registered output slot
module mux_n_para_1_reg
    import alu_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int W       = 8,
    parameter  int MODE_RR = 0,
    localparam int SW      = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] D,
    input  logic [N-1:0]   D_valid,
    output logic [N-1:0]   D_ready,
    input  logic [SW-1:0]  S,
    output logic [W-1:0]   Y,
    output logic           Y_valid,
    input  logic           Y_ready,
    output logic [SW-1:0]  Y_chan
);

    logic [W-1:0]  r_y;
    logic          r_y_valid;
    logic [SW-1:0] r_y_chan;

    logic          w_load_ok;
    logic          w_load;
    logic [N-1:0]  w_gnt;
    logic [SW-1:0] w_gnt_id;

    assign w_load_ok = !r_y_valid || Y_ready;
    assign w_load    = rst_n && w_load_ok && (|w_gnt);
    assign D_ready   = (rst_n && w_load_ok) ? w_gnt : '0;

    generate
        if (MODE_RR == alu_pkg::MODE_RR) begin : g_rr
            logic [SW-1:0] r_rr_ptr;
            logic          w_unused_s;

            assign w_unused_s = ^S;

            rr_arbiter #(.N(N)) u_arb (
                .req    (D_valid),
                .ptr    (r_rr_ptr),
                .en     (1'b1),
                .gnt    (w_gnt),
                .gnt_id (w_gnt_id)
            );

            // Pointer moves only on an actual load, so stalls never skip a channel.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rr_ptr <= SW'(N - 1);
                end else if (w_load) begin
                    r_rr_ptr <= w_gnt_id;
                end
            end
        end else begin : g_sel
            // Out-of-range S matches no channel and therefore yields no grant.
            always_comb begin
                w_gnt = '0;
                for (int i = 0; i < N; i++) begin
                    w_gnt[i] = D_valid[i] && (int'(S) == i);
                end
            end
            assign w_gnt_id = S;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_chan  <= '0;
        end else if (w_load) begin
            r_y       <= D[int'(w_gnt_id)*W +: W];
            r_y_valid <= 1'b1;
            r_y_chan  <= w_gnt_id;
        end else if (Y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign Y       = r_y;
    assign Y_valid = r_y_valid;
    assign Y_chan  = r_y_chan;

endmodule

// File: tb/tb_mux_n_para_1_reg.sv
// tb/tb_mux_n_para_1_reg.sv - directed self-checking bench for mux_n_para_1_reg
module tb_mux_n_para_1_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // select mode, N=4
    logic [31:0] s4_d;
    logic [3:0]  s4_dv, s4_dr;
    logic [1:0]  s4_s, s4_yc;
    logic [7:0]  s4_y;
    logic        s4_yv, s4_yr;

    // round-robin mode, N=4
    logic [31:0] rr_d;
    logic [3:0]  rr_dv, rr_dr;
    logic [1:0]  rr_s, rr_yc;
    logic [7:0]  rr_y;
    logic        rr_yv, rr_yr;

    // select mode, N=5
    logic [39:0] s5_d;
    logic [4:0]  s5_dv, s5_dr;
    logic [2:0]  s5_s, s5_yc;
    logic [7:0]  s5_y;
    logic        s5_yv, s5_yr;

    mux_n_para_1_reg #(.N(4), .W(8), .MODE_RR(0)) u_s4 (
        .clk(clk), .rst_n(rst_n), .D(s4_d), .D_valid(s4_dv), .D_ready(s4_dr), .S(s4_s),
        .Y(s4_y), .Y_valid(s4_yv), .Y_ready(s4_yr), .Y_chan(s4_yc)
    );

    mux_n_para_1_reg #(.N(4), .W(8), .MODE_RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .D(rr_d), .D_valid(rr_dv), .D_ready(rr_dr), .S(rr_s),
        .Y(rr_y), .Y_valid(rr_yv), .Y_ready(rr_yr), .Y_chan(rr_yc)
    );

    mux_n_para_1_reg #(.N(5), .W(8), .MODE_RR(0)) u_s5 (
        .clk(clk), .rst_n(rst_n), .D(s5_d), .D_valid(s5_dv), .D_ready(s5_dr), .S(s5_s),
        .Y(s5_y), .Y_valid(s5_yv), .Y_ready(s5_yr), .Y_chan(s5_yc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] seq_e [4];
    logic [3:0] exp_dr;

    initial begin
        seq_e = '{2'd0, 2'd3, 2'd0, 2'd3};

        rst_n = 1'b0;
        s4_d  = {8'h44, 8'h33, 8'h22, 8'h11};
        s4_dv = 4'hF; s4_s = 2'd0; s4_yr = 1'b1;
        rr_d  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        rr_dv = 4'hF; rr_s = 2'd0; rr_yr = 1'b1;
        s5_d  = {8'h5E, 8'h5D, 8'h5C, 8'h5B, 8'h5A};
        s5_dv = 5'h1F; s5_s = 3'd7; s5_yr = 1'b1;

        #1;
        chk("rst_dready_s4", 32'(s4_dr), 32'h0);
        chk("rst_dready_rr", 32'(rr_dr), 32'h0);
        tick();
        chk("rst_dready_rr_c2", 32'(rr_dr), 32'h0);
        tick();
        chk("rst_yvalid_s4", 32'(s4_yv), 32'h0);
        chk("rst_y_s4", 32'(s4_y), 32'h0);
        chk("rst_ychan_s4", 32'(s4_yc), 32'h0);
        chk("rst_yvalid_rr", 32'(rr_yv), 32'h0);
        chk("rst_y_rr", 32'(rr_y), 32'h0);

        // full round-robin sweep, starting from channel 0
        rst_n = 1'b1;
        s4_dv = 4'h0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_dr = 4'b0001 << (i % 4);
            chk("rr_dready", 32'(rr_dr), 32'(exp_dr));
            chk("s5_dready_s7", 32'(s5_dr), 32'h0);
            tick();
            chk("rr_chan", 32'(rr_yc), 32'(i % 4));
            chk("rr_data", 32'(rr_y), 32'(8'hD0 + i % 4));
            chk("s5_yvalid_s7", 32'(s5_yv), 32'h0);
        end

        // external select: S=2 hits, then S=3 with channel 3 invalid
        rr_dv = 4'h0;
        s4_d  = {8'h44, 8'hA5, 8'h22, 8'h11};
        s4_dv = 4'b0100; s4_s = 2'd2;
        #1 chk("sel_dready_s2", 32'(s4_dr), 32'h4);
        tick();
        chk("sel_y_s2", 32'(s4_y), 32'hA5);
        chk("sel_chan_s2", 32'(s4_yc), 32'h2);
        chk("sel_yvalid_s2", 32'(s4_yv), 32'h1);
        s4_s = 2'd3; s4_dv = 4'b0111;
        #1 chk("sel_dready_s3_invalid", 32'(s4_dr), 32'h0);
        tick();
        chk("sel_yvalid_drain", 32'(s4_yv), 32'h0);
        chk("sel_y_hold", 32'(s4_y), 32'hA5);

        // backpressure: three stalled cycles, then transfer and refill together
        s4_d  = {8'h44, 8'hA5, 8'h3C, 8'h11};
        s4_s  = 2'd1; s4_dv = 4'b0010;
        tick();
        chk("bp_load", 32'(s4_y), 32'h3C);
        s4_yr = 1'b0;
        s4_d  = {8'h44, 8'hA5, 8'h5A, 8'h77};
        s4_s  = 2'd0; s4_dv = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_dready_stall", 32'(s4_dr), 32'h0);
            tick();
            chk("bp_y_stable", 32'(s4_y), 32'h3C);
            chk("bp_chan_stable", 32'(s4_yc), 32'h1);
            chk("bp_yvalid_stable", 32'(s4_yv), 32'h1);
        end
        s4_yr = 1'b1;
        #1 chk("bp_dready_release", 32'(s4_dr), 32'h1);
        tick();
        chk("bp_refill_y", 32'(s4_y), 32'h77);
        chk("bp_refill_chan", 32'(s4_yc), 32'h0);
        chk("bp_refill_valid", 32'(s4_yv), 32'h1);
        s4_dv = 4'h0;
        tick();
        chk("bp_final_drain", 32'(s4_yv), 32'h0);

        // round-robin skip and wrap over channels 0 and 3
        rr_dv = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_dr = 4'b0001 << seq_e[i];
            chk("rrw_dready", 32'(rr_dr), 32'(exp_dr));
            tick();
            chk("rrw_chan", 32'(rr_yc), 32'(seq_e[i]));
        end

        // stall in the middle of a sweep must not skip channel 2
        rr_dv = 4'hF;
        tick();
        chk("rrs_chan0", 32'(rr_yc), 32'h0);
        tick();
        chk("rrs_chan1", 32'(rr_yc), 32'h1);
        rr_yr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1 chk("rrs_dready_stall", 32'(rr_dr), 32'h0);
            tick();
            chk("rrs_chan_hold", 32'(rr_yc), 32'h1);
            chk("rrs_valid_hold", 32'(rr_yv), 32'h1);
        end
        rr_yr = 1'b1;
        tick();
        chk("rrs_chan2", 32'(rr_yc), 32'h2);
        tick();
        chk("rrs_chan3", 32'(rr_yc), 32'h3);

        // reset while a word is held under backpressure
        rr_yr = 1'b0;
        tick();
        chk("rst_mid_held", 32'(rr_yv), 32'h1);
        rst_n = 1'b0;
        #1 chk("rst_mid_dready", 32'(rr_dr), 32'h0);
        tick();
        chk("rst_mid_dropped", 32'(rr_yv), 32'h0);
        rst_n = 1'b1; rr_yr = 1'b1;
        tick();
        chk("rst_mid_first_ch0", 32'(rr_yc), 32'h0);
        chk("rst_mid_first_valid", 32'(rr_yv), 32'h1);

        // N=5: S=7 never grants, S=4 reaches the top channel
        chk("s5_yvalid_s7_end", 32'(s5_yv), 32'h0);
        s5_s = 3'd4; s5_dv = 5'b10000;
        #1 chk("s5_dready_s4", 32'(s5_dr), 32'h10);
        tick();
        chk("s5_y_s4", 32'(s5_y), 32'h5E);
        chk("s5_chan_s4", 32'(s5_yc), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
